// File: rtl/product_acc_pkg.sv
// Shared definitions for the product accumulator slice.
//   - Default widths for the signed product input, the accumulator and the
//     frame-length counter.
//   - Fixed state encoding. It is visible on the top-level dbg_state port, so
//     checkers and waveform viewers can decode it without the enum.
package product_acc_pkg;

  localparam int IN_W_DEF  = 64;
  localparam int ACC_W_DEF = 72;
  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// sat_adder: combinational saturating accumulate step.
//   Sign-extends a signed addend to the accumulator width and adds it to the
//   running total. The add is one bit wider than the accumulator. If the two
//   top bits of that sum differ, the result has left the representable range.
//   The output is then clamped to the extreme on the side of the true sign.
// Ports
//   acc     in   ACC_W  current signed accumulator value
//   addend  in   IN_W   signed value to add
//   sum     out  ACC_W  clamped signed result
//   ovf     out  1      result was clamped
module sat_adder
  import product_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  addend,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] add_ext;
  logic signed [ACC_W:0] raw;

  assign acc_ext = {acc[ACC_W-1], acc};
  // The size cast keeps the operand signed, so the addend is sign-extended.
  // This also works when ACC_W == IN_W.
  assign add_ext = (ACC_W+1)'($signed(addend));
  assign raw     = acc_ext + add_ext;

  // raw[ACC_W] is the true sign of the unbounded sum.
  assign ovf = raw[ACC_W] ^ raw[ACC_W-1];

  always_comb begin
    sum = raw[ACC_W-1:0];
    if (ovf) begin
      sum = raw[ACC_W] ? NEG_MIN : POS_MAX;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmable-length frame of signed products
// into a wide saturating accumulator. It hands the frame total downstream over
// a valid/ready handshake.
//
// Handshake semantics, for both the input and the output side:
//   A transfer happens at a rising clk edge where valid and ready are both 1.
//   The producer holds data stable while valid is high and ready is low.
//   ready depends only on the state register, never on valid.
//
// Frame flow: IDLE --start--> ACCUM --len beats--> DONE --out_ready--> IDLE.
//   start with len==0 goes straight to DONE with a total of 0.
//   start is only sampled in IDLE. In the cycle where DONE hands off the
//   state is still DONE, so a start in that cycle is ignored.
//
// Ports
//   clk        in   1      clock, posedge
//   rst        in   1      synchronous active-high reset; aborts a frame silently
//   start      in   1      begin a frame (sampled in IDLE only)
//   len        in   CNT_W  products in the frame, captured with start
//   in_valid   in   1      in_data holds a product
//   in_ready   out  1      high in ACCUM
//   in_data    in   IN_W   signed product
//   out_valid  out  1      high in DONE
//   out_ready  in   1      downstream accepts the total
//   out_data   out  ACC_W  signed frame total (0 outside DONE)
//   out_sat    out  1      total was clamped at least once (0 outside DONE)
//   busy       out  1      state != IDLE
//   dbg_state  out  2      raw state register (ST_* encoding)
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  state_e           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  logic [ACC_W-1:0] acc_next;
  logic             acc_ovf;
  logic             beat;

  sat_adder #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .acc    (acc),
    .addend (in_data),
    .sum    (acc_next),
    .ovf    (acc_ovf)
  );

  assign beat = in_valid && (state == S_ACCUM);

  // Frame control. acc, cnt and sat change only on start or on a beat.
  // While stalled in DONE, the presented total stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc <= '0;
            sat <= 1'b0;
            cnt <= len;
            state <= (len != '0) ? S_ACCUM : S_DONE;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc <= acc_next;
            // Sticky: a later beat may bring acc back in range, but the flag
            // stays set until the next start.
            sat <= sat | acc_ovf;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign out_data  = out_valid ? acc : '0;
  assign out_sat   = out_valid & sat;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule
